// File: rtl/ext_pkg.sv
// Shared types, widths and the extension function for the ext_arbiter block.
// Byte-extension mode is compiled in with EXT_BYTE_EN.
package ext_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  // Sign/zero-extend a halfword, or only its low byte when byt is set.
  function automatic logic [WORD_W-1:0] ext_word(input logic [HALF_W-1:0] data,
                                                 input logic              sgn,
                                                 input logic              byt);
    logic [WORD_W-1:0] r;
    if (byt) begin
      r = sgn ? {{(WORD_W-BYTE_W){data[BYTE_W-1]}}, data[BYTE_W-1:0]}
              : {{(WORD_W-BYTE_W){1'b0}}, data[BYTE_W-1:0]};
    end else begin
      r = sgn ? {{(WORD_W-HALF_W){data[HALF_W-1]}}, data}
              : {{(WORD_W-HALF_W){1'b0}}, data};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned SRCW = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [SRCW-1:0] rr,
  output logic [NREQ-1:0] grant,
  output logic [SRCW-1:0] idx,
  output logic            any
);

  // Scan offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      cand = int'(rr) + i;
      if (cand >= int'(NREQ)) cand = cand - int'(NREQ);
      if (valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = SRCW'(cand);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one 16->32 extension datapath with a one-entry
// registered output stage. EXT_BYTE_EN adds per-requester byte extension.
module ext_arbiter
  import ext_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned SRCW = 2
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [NREQ-1:0]        Req_Valid,
  output logic [NREQ-1:0]        Req_Ready,
  input  logic [NREQ-1:0]        Req_Signed,
`ifdef EXT_BYTE_EN
  input  logic [NREQ-1:0]        Req_Byte,
`endif
  input  logic [HALF_W*NREQ-1:0] Req_Data,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [WORD_W-1:0]      Out_Data,
  output logic [SRCW-1:0]        Out_Src
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [SRCW-1:0]   src_q, src_d;
  logic [SRCW-1:0]   rr_q, rr_d;
  logic              live_q;

  logic [NREQ-1:0]   pick_grant;
  logic [SRCW-1:0]   pick_idx;
  logic              pick_any;
  logic              load;
  logic              take;
  logic [HALF_W-1:0] sel_data;
  logic              sel_signed;
  logic              sel_byte;

  rr_pick #(.NREQ(NREQ), .SRCW(SRCW)) u_pick (
    .valid (Req_Valid),
    .rr    (rr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grants are blocked until the first clock after reset release.
  assign load = live_q & ((state_q == S_EMPTY) | Out_Ready);
  assign take = load & pick_any;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next state: fill on grant, drain when popped with nothing to reload.
  always_comb begin
    state_d = state_q;
    if (take)                                  state_d = S_FULL;
    else if (state_q == S_FULL && Out_Ready)   state_d = S_EMPTY;
  end

  // FSM outputs.
  always_comb begin
    Out_Valid = (state_q == S_FULL);
    Req_Ready = load ? pick_grant : '0;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_data   = '0;
    sel_signed = 1'b0;
    sel_byte   = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_grant[i]) begin
        sel_data   = Req_Data[i*HALF_W +: HALF_W];
        sel_signed = Req_Signed[i];
`ifdef EXT_BYTE_EN
        sel_byte   = Req_Byte[i];
`endif
      end
    end
  end

  // Output register and pointer next values; all hold unless a grant occurs.
  always_comb begin
    data_d = data_q;
    src_d  = src_q;
    rr_d   = rr_q;
    if (take) begin
      data_d = ext_word(sel_data, sel_signed, sel_byte);
      src_d  = pick_idx;
      rr_d   = (pick_idx == SRCW'(NREQ - 1)) ? '0 : pick_idx + SRCW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q <= '0;
      src_q  <= '0;
      rr_q   <= '0;
      live_q <= 1'b0;
    end else begin
      data_q <= data_d;
      src_q  <= src_d;
      rr_q   <= rr_d;
      live_q <= 1'b1;
    end
  end

  assign Out_Data = data_q;
  assign Out_Src  = src_q;

endmodule

// File: doc/ext_arbiter.md
# ext_arbiter

Shares one 16→32-bit immediate/halfword extension datapath among NREQ requesters (decode immediate path, load-halfword alignment, branch-offset unit). Round-robin arbitration, valid/ready handshakes on every requester and on the single consumer, and a one-entry registered output stage. It sits between the requesting pipeline units and the shared extension result bus.

## Interface
- NREQ, 2: number of requesters, 2..4.
- SRCW, 2: width of the source-index output; must satisfy 2^SRCW ≥ NREQ.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- Req_Valid  in  NREQ  request i is presenting an operand.
- Req_Ready  out  NREQ  request i is accepted this cycle (one-hot or zero).
- Req_Signed  in  NREQ  1 = sign-extend, 0 = zero-extend, per requester.
- Req_Data  in  16*NREQ  operand i occupies bits [16i+15:16i].
- Out_Valid  out  1  Out_Data/Out_Src hold a result.
- Out_Ready  in  1  consumer accepts the result.
- Out_Data  out  32  extended result.
- Out_Src  out  SRCW  index of the requester that produced Out_Data.

## Operation
- FSM has two states:
  - S_EMPTY: output register empty.
  - S_FULL: output register holds an unconsumed result.
- Load condition: load = (state==S_EMPTY) | Out_Ready.
- Grant: when load=1 and any Req_Valid is high, exactly one requester is granted.
  - The winner is the first valid requester found scanning upward, with wrap-around, starting at pointer Rr.
  - Req_Ready[g] = 1 for that requester only.
  - Req_Ready is combinational from Req_Valid, Rr and state. It never depends on Req_Data.
- On grant:
  - Out_Data <= Req_Signed[g] ? {16{d[15]}, d} : {16'b0, d}.
  - Out_Src <= g.
  - Rr <= (g+1) mod NREQ.
  - Next state is S_FULL.
- Transitions:
  - S_FULL, Out_Ready=1, no valid request: go to S_EMPTY, Out_Valid falls.
  - S_FULL, Out_Ready=1, a valid request: reload and stay in S_FULL (back-to-back, no bubble).
  - S_FULL, Out_Ready=0: hold Out_Data/Out_Src stable; all Req_Ready = 0.
- Requester rules: a requester must hold Valid, Data and Signed stable until it sees Ready. Dropping Valid before Ready is allowed and simply withdraws the request.
- Rr changes only on a grant.
- Out_Valid = (state==S_FULL).

## Timing
- Reset values: state=S_EMPTY, Out_Valid=0, Out_Data=0, Out_Src=0, Rr=0, Req_Ready=0.
- Latency: an operand accepted in cycle n appears on Out_Data in cycle n+1.
- Throughput: one result per cycle while Out_Ready=1.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ grants.
- Wrap-around: with Rr=NREQ-1 and only requester 0 valid, requester 0 is granted and Rr becomes 1.
- Simultaneous pop and push: handled as a reload; no loss and no duplication.
- Reset mid-operation: any held result is discarded and Out_Valid falls asynchronously. No Req_Ready is asserted during reset or in the cycle it is released.

## Configuration
- EXT_BYTE_EN compiled in:
  - Adds input Req_Byte[NREQ-1:0].
  - When Req_Byte[g]=1, only d[7:0] is extended: signed gives {24{d[7]}, d[7:0]}, unsigned gives {24'b0, d[7:0]}.
  - Req_Byte=1 overrides halfword mode.
- EXT_BYTE_EN absent: the port does not exist; halfword extension only.

## Structure
- Shared package ext_pkg holds:
  - the state enumeration (S_EMPTY, S_FULL);
  - the constants HALF_W=16, WORD_W=32, BYTE_W=8;
  - the function ext_word(data, signed, byte), used by both this block and its bench model.
- One sub-module, rr_pick: combinational round-robin picker, inputs (valid vector, Rr), outputs (one-hot grant, index, any). Instantiated once.

## Test plan
- Reset, then Req_Valid=01, Req_Data[15:0]=16'h8001, Req_Signed=1 → Req_Ready=01. Next cycle Out_Valid=1, Out_Data=32'hFFFF8001, Out_Src=0.
- Same operand with Req_Signed=0 → Out_Data=32'h00008001. Operand 16'h7FFF signed → 32'h00007FFF.
- Both requesters valid for 6 cycles, Out_Ready=1 → Out_Src sequence 0,1,0,1,0,1 with no idle cycle.
- Output full and Out_Ready=0 for 3 cycles with both requesters valid → Req_Ready=00, Out_Data stable. Out_Ready=1 → pop and reload in the same cycle.
- Rst_n asserted while Out_Valid=1 → Out_Valid=0 immediately. After release the first grant goes to requester 0.
- EXT_BYTE_EN build, Req_Byte=1, Signed=1, Data=16'h1280 → Out_Data=32'hFFFFFF80.
